// File: rtl/serial_mag_comparator.sv
// Purpose      : multi-cycle magnitude comparator, MSB-first, DIGIT_W bits per clock, early exit on first differing digit.
// Latency      : start sampled at edge E gives done in the cycle after edge E+k, k = index of first differing digit (NDIG if equal).
// Backpressure : none; start is ignored while busy, and a start in the done cycle is accepted (no bubble).
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start, signed_mode, ip1, ip2 request and operands, latched only when idle
//   busy                         high during the compare cycles
//   done                         one-cycle pulse when the result registers update
//   ip1_gt_ip2/eq/lt             registered result, held until the next done
module serial_mag_comparator #(
    parameter int WIDTH   = 32,
    parameter int DIGIT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] ip1,
    input  logic [WIDTH-1:0] ip2,
    output logic             busy,
    output logic             done,
    output logic             ip1_gt_ip2,
    output logic             ip1_eq_ip2,
    output logic             ip1_lt_ip2
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    // Flipping the sign bit of the top digit maps two's-complement order
    // onto unsigned order, so one unsigned comparator serves both modes.
    localparam logic [DIGIT_W-1:0] SIGN_MASK = DIGIT_W'(1) << (DIGIT_W - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(NDIG - 1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("serial_mag_comparator: WIDTH must be >= 2");
        end
        if ((WIDTH % DIGIT_W) != 0) begin : g_bad_digit
            $error("serial_mag_comparator: WIDTH must be a multiple of DIGIT_W");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               smode_q, smode_d;
    logic               done_q, done_d;
    logic               gt_q, gt_d;
    logic               eq_q, eq_d;
    logic               lt_q, lt_d;

    logic [DIGIT_W-1:0] da;
    logic [DIGIT_W-1:0] db;
    logic [DIGIT_W-1:0] da_c;
    logic [DIGIT_W-1:0] db_c;
    logic               sign_digit;

    // Top digit of each shift register; the sign adjustment applies only to
    // the first (most significant) digit of a signed compare.
    always_comb begin
        da         = sa_q[WIDTH-1 -: DIGIT_W];
        db         = sb_q[WIDTH-1 -: DIGIT_W];
        sign_digit = smode_q && (cnt_q == '0);
        da_c       = sign_digit ? (da ^ SIGN_MASK) : da;
        db_c       = sign_digit ? (db ^ SIGN_MASK) : db;
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        smode_d = smode_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = ip1;
                    sb_d    = ip2;
                    smode_d = signed_mode;
                    cnt_d   = '0;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (da_c != db_c) begin
                    gt_d    = (da_c > db_c);
                    lt_d    = (da_c < db_c);
                    eq_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    sa_d  = sa_q << DIGIT_W;
                    sb_d  = sb_q << DIGIT_W;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            smode_q <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            smode_q <= smode_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign busy       = (state_q == CMP);
    assign done       = done_q;
    assign ip1_gt_ip2 = gt_q;
    assign ip1_eq_ip2 = eq_q;
    assign ip1_lt_ip2 = lt_q;

endmodule
